// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: direction/output registers, synchronised inputs, edge-triggered sticky interrupts.
// Optional GPIO_DEBOUNCE_EN inserts a per-pin DEBOUNCE_CYCLES stability filter after the synchroniser.

module gpio_pin_in #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_i,
  output logic filt_o,
  output logic filt_d_o
);
  logic sync1_q, sync2_q, filt_q, filt_d_q;

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_chk
    $error("gpio_pin_in: DEBOUNCE_CYCLES must be >= 2");
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_d_q <= 1'b0;
    end else begin
      sync1_q  <= pad_i;
      sync2_q  <= sync1_q;
      filt_d_q <= filt_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt_q;

  // Counts cycles of disagreement; any agreement restarts it, so short glitches never land.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) filt_q <= 1'b0;
    else       filt_q <= sync2_q;
  end
`endif

  assign filt_o   = filt_q;
  assign filt_d_o = filt_d_q;
endmodule

module gpio_port_ctrl #(
  parameter int NUMGPIO         = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [NUMGPIO-1:0]    dataIO,
  input  logic                  wrEn,
  input  logic [2:0]            wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [2:0]            rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  output logic                  irq
);
  localparam logic [2:0] A_DIR  = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_IEN  = 3'd5;
  localparam logic [2:0] A_PEND = 3'd6;

  if (NUMGPIO < 1 || NUMGPIO > 32 || DATA_WIDTH < NUMGPIO) begin : g_cfg_chk
    $error("gpio_port_ctrl: need 1 <= NUMGPIO <= 32 and DATA_WIDTH >= NUMGPIO");
  end

  logic [NUMGPIO-1:0]    dir_q, out_q, rise_q, fall_q, ien_q, pend_q, pend_d;
  logic [NUMGPIO-1:0]    filt, filt_d, wr_bits, edge_ev, rd_sel;
  logic [DATA_WIDTH-1:0] rd_mux, rd_data_q;
  logic                  rd_valid_q, irq_q;

  assign wr_bits = wrData[NUMGPIO-1:0];

  if (DATA_WIDTH > NUMGPIO) begin : g_wr_hi
    logic unused_wr_hi;
    assign unused_wr_hi = ^wrData[DATA_WIDTH-1:NUMGPIO];
  end

  // Inputs are sampled on every pin, so driven pins read back their own pad level.
  for (genvar i = 0; i < NUMGPIO; i++) begin : g_pin
    assign dataIO[i] = dir_q[i] ? out_q[i] : 1'bz;
    gpio_pin_in #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
      .clock    (clock),
      .reset    (reset),
      .pad_i    (dataIO[i]),
      .filt_o   (filt[i]),
      .filt_d_o (filt_d[i])
    );
  end

  assign edge_ev = (filt & ~filt_d & rise_q) | (~filt & filt_d & fall_q);

  // Clear is applied first so a same-cycle edge re-sets the bit.
  always_comb begin
    pend_d = pend_q;
    if (wrEn && wrAddr == A_PEND) pend_d = pend_q & ~wr_bits;
    pend_d = pend_d | edge_ev;
  end

  always_comb begin
    rd_sel = '0;
    case (rdAddr)
      A_DIR:   rd_sel = dir_q;
      A_OUT:   rd_sel = out_q;
      A_IN:    rd_sel = filt;
      A_RISE:  rd_sel = rise_q;
      A_FALL:  rd_sel = fall_q;
      A_IEN:   rd_sel = ien_q;
      A_PEND:  rd_sel = pend_q;
      default: rd_sel = '0;
    endcase
    rd_mux = '0;
    rd_mux[NUMGPIO-1:0] = rd_sel;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_q      <= '0;
      out_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      ien_q      <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wrEn) begin
        case (wrAddr)
          A_DIR:   dir_q  <= wr_bits;
          A_OUT:   out_q  <= wr_bits;
          A_RISE:  rise_q <= wr_bits;
          A_FALL:  fall_q <= wr_bits;
          A_IEN:   ien_q  <= wr_bits;
          default: ;
        endcase
      end
      pend_q     <= pend_d;
      irq_q      <= |(pend_q & ien_q);
      rd_valid_q <= rdEn;
      if (rdEn) rd_data_q <= rd_mux;
    end
  end

  assign rdData  = rd_data_q;
  assign rdValid = rd_valid_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Randomised and directed bench for gpio_port_ctrl against a pad-history reference model.
module tb_gpio_port_ctrl;
  localparam int N   = 8;
  localparam int DEB = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rdData;
  logic        rdValid, irq;
  logic [N-1:0] ext_drv = '0;
  wire  [N-1:0] pad;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Reference model: register file plus a pad history; IN is the pad seen LAT-1 edges ago.
  logic [N-1:0] m_dir = '0, m_out = '0, m_rise = '0, m_fall = '0, m_ien = '0, m_pend = '0;
  logic [N-1:0] hist [0:LAT];
  logic [31:0]  m_rd = '0;
  logic         m_rdv = 1'b0, m_irq = 1'b0;

  wire [N-1:0] ext_en  = ~m_dir;
  wire [N-1:0] m_in    = hist[LAT-1];
  wire [N-1:0] m_in_d  = hist[LAT];
  wire [N-1:0] m_ev    = (m_in & ~m_in_d & m_rise) | (~m_in & m_in_d & m_fall);
  wire [N-1:0] exp_pad = (m_dir & m_out) | (~m_dir & ext_drv);
  wire [N-1:0] m_clr   = (wr_en && wr_addr == 3'd6) ? wr_data[N-1:0] : '0;

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_drv[i] : 1'bz;
  end

  function automatic logic [31:0] m_regval(input logic [2:0] a);
    logic [N-1:0] v;
    case (a)
      3'd0: v = m_dir;
      3'd1: v = m_out;
      3'd2: v = m_in;
      3'd3: v = m_rise;
      3'd4: v = m_fall;
      3'd5: v = m_ien;
      3'd6: v = m_pend;
      default: v = '0;
    endcase
    return {{(32-N){1'b0}}, v};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_dir <= '0; m_out <= '0; m_rise <= '0; m_fall <= '0; m_ien <= '0; m_pend <= '0;
      m_rd <= '0; m_rdv <= 1'b0; m_irq <= 1'b0;
      for (int i = 0; i <= LAT; i++) hist[i] <= '0;
    end else begin
      for (int i = LAT; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= exp_pad;
      if (wr_en) begin
        case (wr_addr)
          3'd0: m_dir  <= wr_data[N-1:0];
          3'd1: m_out  <= wr_data[N-1:0];
          3'd3: m_rise <= wr_data[N-1:0];
          3'd4: m_fall <= wr_data[N-1:0];
          3'd5: m_ien  <= wr_data[N-1:0];
          default: ;
        endcase
      end
      m_pend <= (m_pend & ~m_clr) | m_ev;
      m_irq  <= |(m_pend & m_ien);
      m_rdv  <= rd_en;
      if (rd_en) m_rd <= m_regval(rd_addr);
    end
  end

  gpio_port_ctrl #(.NUMGPIO(N), .DATA_WIDTH(32), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .dataIO(pad),
    .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
    .rdEn(rd_en), .rdAddr(rd_addr), .rdData(rdData), .rdValid(rdValid), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clock);
    rd_en = 1'b0;
    d = rdData; v = rdValid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    ext_drv = '0;
    tick(3);
    reset = 1'b0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid got=%b want=0", rdValid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    checks++; if (rdData !== 32'h0) begin failures++; $display("FAIL reset_rddata got=%h want=0", rdData); end
    tick(LAT);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d, v);
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL reset_read_valid idx=%0d got=%b want=1", a, v); end
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_read_data idx=%0d got=%h want=0", a, d); end
      tick(1);
      checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL reset_valid_pulse idx=%0d got=%b want=0", a, rdValid); end
    end
    ext_drv = N'($urandom);
    tick(LAT);
    rd(3'd2, d, v);
    checks++; if (d !== {24'h0, ext_drv}) begin failures++; $display("FAIL reset_pins_hiz_in got=%h want=%h", d, ext_drv); end
    checks++; if (pad !== ext_drv) begin failures++; $display("FAIL reset_pins_hiz_pad got=%h want=%h", pad, ext_drv); end
    ext_drv = '0;
    tick(LAT + 2);
  endtask

  task automatic test_output_drive();
    logic [31:0] d; logic v;
    ext_drv = 8'h30;
    wr(3'd0, 32'hFFFF_FF0F);
    wr(3'd1, 32'h1234_56A5);
    checks++; if (pad[3:0] !== 4'b0101) begin failures++; $display("FAIL drive_low_nibble got=%b want=0101", pad[3:0]); end
    checks++; if (pad[7:4] !== 4'h3) begin failures++; $display("FAIL drive_high_nibble_hiz got=%h want=3", pad[7:4]); end
    tick(LAT);
    rd(3'd2, d, v);
    checks++; if (d !== 32'h35) begin failures++; $display("FAIL drive_in_readback got=%h want=35", d); end
    rd(3'd0, d, v);
    checks++; if (d !== 32'h0F) begin failures++; $display("FAIL drive_dir_upper_bits got=%h want=0f", d); end
    wr(3'd0, 32'h0); wr(3'd1, 32'h0);
    ext_drv = '0;
    tick(LAT + 2);
  endtask

  task automatic test_rise_irq();
    logic [31:0] d; logic v;
    wr(3'd3, 32'h10); wr(3'd5, 32'h10);
    ext_drv[4] = 1'b1;
    tick(LAT + 1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_irq_early got=%b want=0", irq); end
    rd(3'd6, d, v);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL rise_pend got=%h want=10", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq got=%b want=1", irq); end
    wr(3'd6, 32'h10);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq_hold got=%b want=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_irq_clear got=%b want=0", irq); end
    rd(3'd6, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rise_pend_clear got=%h want=0", d); end
    wr(3'd3, 32'h0); wr(3'd5, 32'h0);
  endtask

  task automatic test_fall_masked();
    logic [31:0] d; logic v;
    wr(3'd4, 32'h01); wr(3'd5, 32'h0);
    ext_drv[0] = 1'b1;
    tick(LAT + 2);
    rd(3'd6, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL fall_no_event_on_rise got=%h want=0", d); end
    ext_drv[0] = 1'b0;
    tick(LAT + 2);
    rd(3'd6, d, v);
    checks++; if (d !== 32'h01) begin failures++; $display("FAIL fall_pend got=%h want=01", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_irq_masked got=%b want=0", irq); end
    wr(3'd5, 32'h01);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_irq_same_cycle got=%b want=0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_irq_unmask got=%b want=1", irq); end
    wr(3'd6, 32'h01); wr(3'd5, 32'h0); wr(3'd4, 32'h0);
    tick(2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_cleanup_irq got=%b want=0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic v;
    wr(3'd3, 32'h04);
    ext_drv[2] = 1'b1;
    tick(LAT);
    wr(3'd6, 32'h04);
    rd(3'd6, d, v);
    checks++; if (d !== 32'h04) begin failures++; $display("FAIL collision_event_wins got=%h want=04", d); end
    wr(3'd6, 32'h04);
    rd(3'd6, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL collision_later_clear got=%h want=0", d); end
    wr(3'd3, 32'h0);
  endtask

  task automatic test_midop_reset();
    logic [31:0] d; logic v;
    ext_drv = '0;
    tick(LAT + 2);
    wr(3'd3, 32'hFF); wr(3'd5, 32'hFF); wr(3'd1, 32'hFF); wr(3'd0, 32'hFF);
    tick(LAT + 2);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL midop_irq_before got=%b want=1", irq); end
    checks++; if (pad !== 8'hFF) begin failures++; $display("FAIL midop_pad_before got=%h want=ff", pad); end
    rd(3'd6, d, v);
    checks++; if (d !== 32'hFF) begin failures++; $display("FAIL midop_pend_readback got=%h want=ff", d); end
    rd_en = 1'b1; rd_addr = 3'd3;
    #2 reset = 1'b1;
    #1;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL midop_rdvalid got=%b want=0", rdValid); end
    checks++; if (rdData !== 32'h0) begin failures++; $display("FAIL midop_rddata got=%h want=0", rdData); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midop_irq got=%b want=0", irq); end
    checks++; if (pad !== ext_drv) begin failures++; $display("FAIL midop_pad_hiz got=%h want=%h", pad, ext_drv); end
    @(negedge clock);
    rd_en = 1'b0;
    tick(1);
    reset = 1'b0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL midop_read_dropped got=%b want=0", rdValid); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d, v);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL midop_reg_cleared idx=%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
`ifdef GPIO_DEBOUNCE_EN
      wr_addr = 3'($urandom_range(2, 7));
`else
      wr_addr = 3'($urandom_range(0, 7));
`endif
      wr_data = $urandom;
      rd_en   = ($urandom_range(0, 9) < 4);
      rd_addr = 3'($urandom_range(0, 7));
`ifdef GPIO_DEBOUNCE_EN
      if (hold == 0) begin ext_drv = N'($urandom); hold = DEB + 4; end else hold--;
`else
      if ($urandom_range(0, 9) < 3) ext_drv = N'($urandom);
`endif
      @(negedge clock);
      checks++; if (rdValid !== m_rdv) begin failures++; $display("FAIL rand_rdvalid cyc=%0d got=%b want=%b", c, rdValid, m_rdv); end
      checks++; if (rdData !== m_rd) begin failures++; $display("FAIL rand_rddata cyc=%0d got=%h want=%h", c, rdData, m_rd); end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", c, irq, m_irq); end
      checks++; if (pad !== exp_pad) begin failures++; $display("FAIL rand_pad cyc=%0d got=%h want=%h", c, pad, exp_pad); end
    end
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d; logic v;
    reset = 1'b1; ext_drv = '0; tick(2); reset = 1'b0;
    wr(3'd3, 32'h02);
    ext_drv[1] = 1'b1; tick(10); ext_drv[1] = 1'b0; tick(30);
    rd(3'd2, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL deb_glitch_in got=%h want=0", d); end
    rd(3'd6, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL deb_glitch_pend got=%h want=0", d); end
    ext_drv[1] = 1'b1; tick(DEB + 1);
    rd(3'd2, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL deb_in_early got=%h want=0", d); end
    rd(3'd2, d, v);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL deb_in_settled got=%h want=02", d); end
    tick(1);
    rd(3'd6, d, v);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL deb_pend got=%h want=02", d); end
    ext_drv[1] = 1'b0; tick(8);
    reset = 1'b1; tick(1); reset = 1'b0;
    rd(3'd2, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL deb_reset_in got=%h want=0", d); end
  endtask
`endif

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_output_drive();
    test_rise_irq();
    test_fall_masked();
    test_collision();
    test_midop_reset();
    test_random();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
